vector_hazard_controller: RTL and testbench
===========================================

Name: vector_hazard_controller

Overview:
- Hazard and forwarding controller for the scalar/vector 5-stage pipeline (F, D, E, M, WB).
- Supports multi-cycle vector operations that occupy E for MULCYCLES cycles. A sequential FSM and counter hold F/D/E and insert bubbles into M while such an operation runs.
- Also performs scalar/vector operand forwarding from M and WB, load-use stall detection, and taken-branch flush arbitration.

Parameters:
ADDRESSWIDTH, 4, register address width shared by the scalar and vector register files
MULCYCLES, 3, E-stage occupancy of a multi-cycle vector op; legal range 1..16; 1 disables the FSM
CNTWIDTH, 4, counter width; must satisfy 2**CNTWIDTH >= MULCYCLES

Ports:
clk  in  1  pipeline clock
reset  in  1  reset, synchronous, active-high
writeEnableScalarM, writeEnableScalarWB  in  1  scalar RF write enable of instruction in M / WB
writeEnableVectorM, writeEnableVectorWB  in  1  vector RF write enable of instruction in M / WB
isScalarD, isScalarE, isScalarM, isScalarWB  in  1  instruction in stage is scalar
isVectorScalarD, isVectorScalarE  in  1  vector op whose operand 2 is scalar
loadE  in  1  instruction in E is a load (result from memory)
takeBranchE  in  1  branch resolved taken in E
multiCycleE  in  1  instruction in E is a multi-cycle vector op
writeAddressE, writeAddressM, writeAddressWB  in  ADDRESSWIDTH  destination register per stage
reg1ReadAddressD, reg2ReadAddressD, reg1ReadAddressE, reg2ReadAddressE  in  ADDRESSWIDTH  source registers
data1ScalarFwdE, data2ScalarFwdE, data1VectorFwdE, data2VectorFwdE  out  2  00 = RF value, 01 = from WB, 10 = from M
stallF, stallD, stallE  out  1  hold pipeline register
flushD, flushE, flushM  out  1  insert bubble into register
holdOperandsE  out  1  E uses operands latched on the multi-cycle entry cycle
busyE  out  1  FSM in BUSY

Behaviour:
- Forwarding (combinational):
  - Scalar operand 1 is forwarded when the E instruction is scalar.
  - Scalar operand 2 is forwarded when the E instruction is scalar or vector-scalar.
  - Vector operand 1 is forwarded when the E instruction is not scalar.
  - Vector operand 2 is forwarded when the E instruction is neither scalar nor vector-scalar.
  - The source must match class and must have the relevant write enable set.
  - An address match in M has priority over a match in WB.
- Load-use (combinational): loadStall = loadE AND a D source matches writeAddressE with the same class rules as forwarding. Forced to 0 while busyE.
- FSM states: IDLE, BUSY. Counter cnt.
  - IDLE:
    - If multiCycleE and !takeBranchE and MULCYCLES > 1: assert stallF, stallD, stallE and flushM this cycle; next cnt = MULCYCLES-2; next state = BUSY.
    - Otherwise stay in IDLE.
  - BUSY, cnt != 0: assert stallF, stallD, stallE, flushM and holdOperandsE; next cnt = cnt-1.
  - BUSY, cnt == 0: assert holdOperandsE only (the op advances to M); next state = IDLE.
  - Total E occupancy is exactly MULCYCLES cycles. Back-to-back multi-cycle ops re-enter BUSY with no gap cycle.
- Outputs with the FSM idle:
  - stallF = stallD = loadStall
  - flushE = loadStall OR takeBranchE
  - flushD = takeBranchE
  - flushM = 0
- In BUSY, flushD and flushE are 0.
- takeBranchE together with multiCycleE in IDLE: the branch wins. Flushes are asserted and the FSM is not entered.
- busyE = (state == BUSY).
- Reset (synchronous):
  - Next state IDLE, cnt = 0.
  - While reset is high, outputs are forced: stalls = 0, flushD = flushE = flushM = 1, forward selectors = 00, holdOperandsE = 0.
  - A reset asserted mid-BUSY aborts the op; stalls drop in the first reset cycle.
- Timing: no combinational path from any stall output back to an input.

Optional Feature:
- HAZARD_PERF_COUNTERS_EN defined:
  - Adds outputs stallCycleCount (32) and flushCount (32).
  - stallCycleCount increments each cycle stallF = 1.
  - flushCount increments each cycle flushE OR flushD = 1.
  - Both counters saturate at all-ones and clear on reset.
- Not defined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Scalar ADD writes r3 in M; scalar E reads reg1 = r3 and reg2 = r3 with WB also writing r3 -> data1ScalarFwdE = data2ScalarFwdE = 10, vector selectors 00.
- Load in E writes r5; vector-scalar op in D reads reg2 = r5 -> stallF = stallD = flushE = 1 for one cycle, then 0.
- MULCYCLES = 3, multiCycleE pulse at cycle 0:
  - cycles 0-1: stallE = flushM = 1
  - cycles 1-2: holdOperandsE = 1, busyE = 1
  - cycle 3: IDLE, all stalls 0
- Two consecutive multi-cycle ops -> stallE high for cycles 0-1 and 3-4, low at cycle 2; no idle bubble between the ops.
- takeBranchE = 1 with multiCycleE = 1 in IDLE -> flushD = flushE = 1, busyE stays 0.
- reset asserted in cycle 1 of BUSY -> stalls 0 in that cycle, all flushes 1; IDLE afterwards. With HAZARD_PERF_COUNTERS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/vector_hazard_controller_if.sv
// Hazard/forwarding bundle between the pipeline and vector_hazard_controller.
// master = pipeline side, slave = controller side.
interface vector_hazard_controller_if #(
  parameter int ADDRESSWIDTH = 4
);
  logic                    writeEnableScalarM;
  logic                    writeEnableScalarWB;
  logic                    writeEnableVectorM;
  logic                    writeEnableVectorWB;
  logic                    isScalarD;
  logic                    isScalarE;
  logic                    isScalarM;
  logic                    isScalarWB;
  logic                    isVectorScalarD;
  logic                    isVectorScalarE;
  logic                    loadE;
  logic                    takeBranchE;
  logic                    multiCycleE;
  logic [ADDRESSWIDTH-1:0] writeAddressE;
  logic [ADDRESSWIDTH-1:0] writeAddressM;
  logic [ADDRESSWIDTH-1:0] writeAddressWB;
  logic [ADDRESSWIDTH-1:0] reg1ReadAddressD;
  logic [ADDRESSWIDTH-1:0] reg2ReadAddressD;
  logic [ADDRESSWIDTH-1:0] reg1ReadAddressE;
  logic [ADDRESSWIDTH-1:0] reg2ReadAddressE;
  logic [1:0]              data1ScalarFwdE;
  logic [1:0]              data2ScalarFwdE;
  logic [1:0]              data1VectorFwdE;
  logic [1:0]              data2VectorFwdE;
  logic                    stallF;
  logic                    stallD;
  logic                    stallE;
  logic                    flushD;
  logic                    flushE;
  logic                    flushM;
  logic                    holdOperandsE;
  logic                    busyE;

  modport master (
    output writeEnableScalarM, writeEnableScalarWB,
    output writeEnableVectorM, writeEnableVectorWB,
    output isScalarD, isScalarE, isScalarM, isScalarWB,
    output isVectorScalarD, isVectorScalarE,
    output loadE, takeBranchE, multiCycleE,
    output writeAddressE, writeAddressM, writeAddressWB,
    output reg1ReadAddressD, reg2ReadAddressD,
    output reg1ReadAddressE, reg2ReadAddressE,
    input  data1ScalarFwdE, data2ScalarFwdE,
    input  data1VectorFwdE, data2VectorFwdE,
    input  stallF, stallD, stallE,
    input  flushD, flushE, flushM,
    input  holdOperandsE, busyE
  );

  modport slave (
    input  writeEnableScalarM, writeEnableScalarWB,
    input  writeEnableVectorM, writeEnableVectorWB,
    input  isScalarD, isScalarE, isScalarM, isScalarWB,
    input  isVectorScalarD, isVectorScalarE,
    input  loadE, takeBranchE, multiCycleE,
    input  writeAddressE, writeAddressM, writeAddressWB,
    input  reg1ReadAddressD, reg2ReadAddressD,
    input  reg1ReadAddressE, reg2ReadAddressE,
    output data1ScalarFwdE, data2ScalarFwdE,
    output data1VectorFwdE, data2VectorFwdE,
    output stallF, stallD, stallE,
    output flushD, flushE, flushM,
    output holdOperandsE, busyE
  );
endinterface

// File: rtl/vector_hazard_controller.sv
// Scalar/vector forwarding, load-use stall, branch flush and multi-cycle hold.
// Optional HAZARD_PERF_COUNTERS_EN adds saturating stall/flush counters.
module vector_hazard_controller #(
  parameter int ADDRESSWIDTH = 4,
  parameter int MULCYCLES    = 3,
  parameter int CNTWIDTH     = 4
) (
  input logic                       clk,
  input logic                       reset,
  vector_hazard_controller_if.slave hz
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0]               stallCycleCount,
  output logic [31:0]               flushCount
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit MC_EN = (MULCYCLES > 1);
  localparam logic [CNTWIDTH-1:0] CNT_INIT =
    CNTWIDTH'(MC_EN ? MULCYCLES - 2 : 0);

  typedef logic [ADDRESSWIDTH-1:0] addr_t;

  state_t              state, state_n;
  logic [CNTWIDTH-1:0] cnt, cnt_n;

  addr_t wa_e, wa_m, wa_wb, r1_d, r2_d, r1_e, r2_e;
  assign wa_e  = hz.writeAddressE;
  assign wa_m  = hz.writeAddressM;
  assign wa_wb = hz.writeAddressWB;
  assign r1_d  = hz.reg1ReadAddressD;
  assign r2_d  = hz.reg2ReadAddressD;
  assign r1_e  = hz.reg1ReadAddressE;
  assign r2_e  = hz.reg2ReadAddressE;

  logic src_s_m, src_s_wb, src_v_m, src_v_wb;
  assign src_s_m  = hz.writeEnableScalarM  & hz.isScalarM;
  assign src_s_wb = hz.writeEnableScalarWB & hz.isScalarWB;
  assign src_v_m  = hz.writeEnableVectorM  & ~hz.isScalarM;
  assign src_v_wb = hz.writeEnableVectorWB & ~hz.isScalarWB;

  logic use_s1, use_s2, use_v1, use_v2;
  assign use_s1 = hz.isScalarE;
  assign use_s2 = hz.isScalarE | hz.isVectorScalarE;
  assign use_v1 = ~hz.isScalarE;
  assign use_v2 = ~hz.isScalarE & ~hz.isVectorScalarE;

  // M beats WB: it holds the younger result
  function automatic logic [1:0] sel(
    input logic use_op,
    input logic hit_m,
    input logic hit_wb
  );
    sel = 2'b00;
    if (use_op && hit_m)       sel = 2'b10;
    else if (use_op && hit_wb) sel = 2'b01;
  endfunction

  logic ld_s1, ld_s2, ld_v1, ld_v2, ld_hit, load_stall, start;
  assign ld_s1 = hz.isScalarD & hz.isScalarE & (r1_d == wa_e);
  assign ld_s2 = (hz.isScalarD | hz.isVectorScalarD)
               & hz.isScalarE & (r2_d == wa_e);
  assign ld_v1 = ~hz.isScalarD & ~hz.isScalarE & (r1_d == wa_e);
  assign ld_v2 = ~hz.isScalarD & ~hz.isVectorScalarD
               & ~hz.isScalarE & (r2_d == wa_e);
  assign ld_hit     = ld_s1 | ld_s2 | ld_v1 | ld_v2;
  assign load_stall = hz.loadE & ld_hit & (state == IDLE);
  assign start      = MC_EN & hz.multiCycleE & ~hz.takeBranchE;

  assign hz.busyE = (state == BUSY);

  always_comb begin
    state_n             = state;
    cnt_n               = cnt;
    hz.stallF           = 1'b0;
    hz.stallD           = 1'b0;
    hz.stallE           = 1'b0;
    hz.flushD           = 1'b0;
    hz.flushE           = 1'b0;
    hz.flushM           = 1'b0;
    hz.holdOperandsE    = 1'b0;
    hz.data1ScalarFwdE  = sel(use_s1, src_s_m & (wa_m == r1_e),
                              src_s_wb & (wa_wb == r1_e));
    hz.data2ScalarFwdE  = sel(use_s2, src_s_m & (wa_m == r2_e),
                              src_s_wb & (wa_wb == r2_e));
    hz.data1VectorFwdE  = sel(use_v1, src_v_m & (wa_m == r1_e),
                              src_v_wb & (wa_wb == r1_e));
    hz.data2VectorFwdE  = sel(use_v2, src_v_m & (wa_m == r2_e),
                              src_v_wb & (wa_wb == r2_e));
    unique case (state)
      IDLE: begin
        if (start) begin
          hz.stallF = 1'b1;
          hz.stallD = 1'b1;
          hz.stallE = 1'b1;
          hz.flushM = 1'b1;
          cnt_n     = CNT_INIT;
          state_n   = BUSY;
        end else begin
          hz.stallF = load_stall;
          hz.stallD = load_stall;
          hz.flushE = load_stall | hz.takeBranchE;
          hz.flushD = hz.takeBranchE;
        end
      end
      BUSY: begin
        hz.holdOperandsE = 1'b1;
        if (cnt != '0) begin
          hz.stallF = 1'b1;
          hz.stallD = 1'b1;
          hz.stallE = 1'b1;
          hz.flushM = 1'b1;
          cnt_n     = cnt - 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // reset aborts any op in flight and bubbles every stage
    if (reset) begin
      hz.stallF          = 1'b0;
      hz.stallD          = 1'b0;
      hz.stallE          = 1'b0;
      hz.flushD          = 1'b1;
      hz.flushE          = 1'b1;
      hz.flushM          = 1'b1;
      hz.holdOperandsE   = 1'b0;
      hz.data1ScalarFwdE = 2'b00;
      hz.data2ScalarFwdE = 2'b00;
      hz.data1VectorFwdE = 2'b00;
      hz.data2VectorFwdE = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycleCount <= '0;
      flushCount      <= '0;
    end else begin
      if (hz.stallF && stallCycleCount != '1)
        stallCycleCount <= stallCycleCount + 32'd1;
      if ((hz.flushE || hz.flushD) && flushCount != '1)
        flushCount <= flushCount + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vector_hazard_controller.sv
// Scoreboarded random + directed bench for vector_hazard_controller.
// Reference model tracks remaining E-occupancy cycles of a multi-cycle op.
module tb_vector_hazard_controller;
  localparam int AW = 4;
  localparam int MC = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vector_hazard_controller_if #(.ADDRESSWIDTH(AW)) hz ();

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stallCycleCount, flushCount;
`endif

  vector_hazard_controller #(
    .ADDRESSWIDTH(AW),
    .MULCYCLES(MC),
    .CNTWIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz.slave)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .stallCycleCount(stallCycleCount),
    .flushCount(flushCount)
`endif
  );

  typedef struct packed {
    logic weSM, weSWB, weVM, weVWB;
    logic sD, sE, sM, sWB, vsD, vsE;
    logic ld, br, mc;
    logic [AW-1:0] waE, waM, waWB, r1D, r2D, r1E, r2E;
  } in_t;

  typedef struct packed {
    logic [1:0] s1, s2, v1, v2;
    logic sF, sD, sE, fD, fE, fM, hold, busy;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model state: further E cycles owed by the running multi-cycle op
  int          m_left = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_fc = 0;

  function automatic logic [1:0] fsel(bit use_op, bit hm, bit hwb);
    if (!use_op) return 2'd0;
    if (hm)      return 2'd2;
    if (hwb)     return 2'd1;
    return 2'd0;
  endfunction

  task automatic model(input in_t v, input bit rst);
    exp_t e;
    bit sm, swb, vm, vwb, ls;
    e = '0;
    e.busy = (m_left > 0);
    e.sc = m_sc;
    e.fc = m_fc;
    sm  = v.weSM  && v.sM;
    swb = v.weSWB && v.sWB;
    vm  = v.weVM  && !v.sM;
    vwb = v.weVWB && !v.sWB;
    e.s1 = fsel(v.sE, sm && v.waM == v.r1E,
                swb && v.waWB == v.r1E);
    e.s2 = fsel(v.sE || v.vsE, sm && v.waM == v.r2E,
                swb && v.waWB == v.r2E);
    e.v1 = fsel(!v.sE, vm && v.waM == v.r1E,
                vwb && v.waWB == v.r1E);
    e.v2 = fsel(!v.sE && !v.vsE, vm && v.waM == v.r2E,
                vwb && v.waWB == v.r2E);
    ls = v.ld && (
      (v.sD && v.sE && v.r1D == v.waE) ||
      ((v.sD || v.vsD) && v.sE && v.r2D == v.waE) ||
      (!v.sD && !v.sE && v.r1D == v.waE) ||
      (!v.sD && !v.vsD && !v.sE && v.r2D == v.waE));
    if (rst) begin
      e.s1 = 0; e.s2 = 0; e.v1 = 0; e.v2 = 0;
      e.fD = 1; e.fE = 1; e.fM = 1;
      m_left = 0;
    end else if (m_left > 0) begin
      e.hold = 1;
      if (m_left > 1) begin
        e.sF = 1; e.sD = 1; e.sE = 1; e.fM = 1;
      end
      m_left--;
    end else if (v.mc && !v.br && MC > 1) begin
      e.sF = 1; e.sD = 1; e.sE = 1; e.fM = 1;
      m_left = MC - 1;
    end else begin
      e.sF = ls; e.sD = ls;
      e.fE = ls || v.br;
      e.fD = v.br;
    end
    if (rst) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (e.sF && m_sc != 32'hFFFF_FFFF) m_sc++;
      if ((e.fE || e.fD) && m_fc != 32'hFFFF_FFFF) m_fc++;
    end
    q.push_back(e);
  endtask

  task automatic apply(input in_t v, input bit rst);
    reset                  = rst;
    hz.writeEnableScalarM  = v.weSM;
    hz.writeEnableScalarWB = v.weSWB;
    hz.writeEnableVectorM  = v.weVM;
    hz.writeEnableVectorWB = v.weVWB;
    hz.isScalarD           = v.sD;
    hz.isScalarE           = v.sE;
    hz.isScalarM           = v.sM;
    hz.isScalarWB          = v.sWB;
    hz.isVectorScalarD     = v.vsD;
    hz.isVectorScalarE     = v.vsE;
    hz.loadE               = v.ld;
    hz.takeBranchE         = v.br;
    hz.multiCycleE         = v.mc;
    hz.writeAddressE       = v.waE;
    hz.writeAddressM       = v.waM;
    hz.writeAddressWB      = v.waWB;
    hz.reg1ReadAddressD    = v.r1D;
    hz.reg2ReadAddressD    = v.r2D;
    hz.reg1ReadAddressE    = v.r1E;
    hz.reg2ReadAddressE    = v.r2E;
  endtask

  task automatic step(input in_t v, input bit rst);
    @(posedge clk);
    #1;
    apply(v, rst);
    model(v, rst);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("data1ScalarFwdE", 32'(hz.data1ScalarFwdE), 32'(e.s1));
      chk("data2ScalarFwdE", 32'(hz.data2ScalarFwdE), 32'(e.s2));
      chk("data1VectorFwdE", 32'(hz.data1VectorFwdE), 32'(e.v1));
      chk("data2VectorFwdE", 32'(hz.data2VectorFwdE), 32'(e.v2));
      chk("stallF", 32'(hz.stallF), 32'(e.sF));
      chk("stallD", 32'(hz.stallD), 32'(e.sD));
      chk("stallE", 32'(hz.stallE), 32'(e.sE));
      chk("flushD", 32'(hz.flushD), 32'(e.fD));
      chk("flushE", 32'(hz.flushE), 32'(e.fE));
      chk("flushM", 32'(hz.flushM), 32'(e.fM));
      chk("holdOperandsE", 32'(hz.holdOperandsE), 32'(e.hold));
      chk("busyE", 32'(hz.busyE), 32'(e.busy));
`ifdef HAZARD_PERF_COUNTERS_EN
      chk("stallCycleCount", stallCycleCount, e.sc);
      chk("flushCount", flushCount, e.fc);
`endif
    end
  end

  in_t z, v;

  initial begin
    z = '0;
    apply(z, 1'b1);
    @(posedge clk);
    step(z, 1'b1);
    step(z, 1'b0);

    // scalar forward: M and WB both write r3, M wins
    v = z;
    v.sE = 1; v.r1E = 3; v.r2E = 3;
    v.weSM = 1; v.sM = 1; v.waM = 3;
    v.weSWB = 1; v.sWB = 1; v.waWB = 3;
    step(v, 1'b0);

    // load-use on vector-scalar operand 2
    v = z;
    v.ld = 1; v.sE = 1; v.waE = 5;
    v.vsD = 1; v.r2D = 5; v.r1D = 1;
    step(v, 1'b0);
    step(z, 1'b0);

    // single multi-cycle op
    v = z;
    v.mc = 1;
    step(v, 1'b0);
    repeat (4) step(z, 1'b0);

    // back-to-back multi-cycle ops
    step(v, 1'b0);
    step(z, 1'b0);
    step(z, 1'b0);
    step(v, 1'b0);
    repeat (4) step(z, 1'b0);

    // branch beats multi-cycle entry
    v = z;
    v.mc = 1; v.br = 1;
    step(v, 1'b0);
    step(z, 1'b0);

    // reset in the first BUSY cycle
    v = z;
    v.mc = 1;
    step(v, 1'b0);
    step(z, 1'b1);
    repeat (3) step(z, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      v.weSM  = 1'($urandom_range(0, 1));
      v.weSWB = 1'($urandom_range(0, 1));
      v.weVM  = 1'($urandom_range(0, 1));
      v.weVWB = 1'($urandom_range(0, 1));
      v.sD    = 1'($urandom_range(0, 1));
      v.sE    = 1'($urandom_range(0, 1));
      v.sM    = 1'($urandom_range(0, 1));
      v.sWB   = 1'($urandom_range(0, 1));
      v.vsD   = 1'($urandom_range(0, 1));
      v.vsE   = 1'($urandom_range(0, 1));
      v.ld    = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 7) == 0);
      v.mc    = ($urandom_range(0, 5) == 0);
      v.waE   = AW'($urandom_range(0, 3));
      v.waM   = AW'($urandom_range(0, 3));
      v.waWB  = AW'($urandom_range(0, 3));
      v.r1D   = AW'($urandom_range(0, 3));
      v.r2D   = AW'($urandom_range(0, 3));
      v.r1E   = AW'($urandom_range(0, 3));
      v.r2E   = AW'($urandom_range(0, 3));
      step(v, ($urandom_range(0, 63) == 0));
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
